// File: rtl/rtc_pkg.sv
// Shared constants for the RTC display path: slot numbering and
// active-low 7-segment patterns (bit6 = a .. bit0 = g).
package rtc_pkg;

   localparam logic [2:0] SLOT_SEC_L = 3'd0;
   localparam logic [2:0] SLOT_SEC_M = 3'd1;
   localparam logic [2:0] SLOT_MIN_L = 3'd2;
   localparam logic [2:0] SLOT_MIN_M = 3'd3;
   localparam logic [2:0] SLOT_HRS_L = 3'd4;
   localparam logic [2:0] SLOT_HRS_M = 3'd5;

   localparam logic [6:0] SEG_OFF = 7'b1111111;

   localparam logic [6:0] SEG_PATTERNS [10] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
   };

endpackage

// File: rtl/rtc_seg_decode.sv
// BCD to active-low 7-segment decoder; codes 10..15 give all segments off.
module rtc_seg_decode
   import rtc_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_OFF;
      if (bcd < 4'd10) seg = SEG_PATTERNS[bcd];
   end

endmodule

// File: rtl/rtc_display_scan.sv
// Multiplexed six-digit HH:MM:SS display scanner with per-slot blanking,
// frame-synchronous digit capture, hours leading-zero blank and colon blink.
module rtc_display_scan
   import rtc_pkg::*;
#(
   parameter int unsigned CLK_HZ         = 50000000,
   parameter int unsigned SCAN_HZ        = 1000,
   parameter int unsigned BLANK_CYCLES   = 4,
   parameter int unsigned SEG_ACTIVE_LOW = 1,
   parameter int unsigned AN_ACTIVE_LOW  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   input  logic [23:0] digits_in,
   input  logic        sec_tick,
   input  logic        lz_suppress,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [5:0]  an,
   output logic [2:0]  digit_idx,
   output logic        frame_done
);

   localparam int unsigned DIV = CLK_HZ / SCAN_HZ;
   localparam int unsigned PW  = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] PRESC_LAST  = PW'(DIV - 1);
   localparam logic [PW-1:0] PRESC_BLANK = PW'(BLANK_CYCLES);

   localparam logic [6:0] SEG_IDLE = (SEG_ACTIVE_LOW != 0) ? SEG_OFF : ~SEG_OFF;
   localparam logic       DP_IDLE  = (SEG_ACTIVE_LOW != 0);
   localparam logic [5:0] AN_IDLE  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

   generate
      if (DIV < BLANK_CYCLES + 2) begin : g_div_check
         $error("rtc_display_scan: CLK_HZ/SCAN_HZ must be at least BLANK_CYCLES+2");
      end
   endgenerate

   logic [PW-1:0] presc;
   logic [23:0]   shadow;
   logic          colon_on;
   logic          primed;

   logic [3:0] cur_bcd;
   logic [6:0] dec_seg;
   logic [6:0] seg_next;
   logic       dp_next;
   logic [5:0] an_next;
   logic       dp_on;
   logic [5:0] an_on;

   always_comb begin
      case (digit_idx)
         SLOT_SEC_L: cur_bcd = shadow[3:0];
         SLOT_SEC_M: cur_bcd = shadow[7:4];
         SLOT_MIN_L: cur_bcd = shadow[11:8];
         SLOT_MIN_M: cur_bcd = shadow[15:12];
         SLOT_HRS_L: cur_bcd = shadow[19:16];
         SLOT_HRS_M: cur_bcd = shadow[23:20];
         default:    cur_bcd = shadow[3:0];
      endcase
   end

   rtc_seg_decode u_decode (
      .bcd (cur_bcd),
      .seg (dec_seg)
   );

   always_comb begin
      seg_next = dec_seg;
      if (lz_suppress && digit_idx == SLOT_HRS_M && shadow[23:20] == 4'd0)
         seg_next = SEG_OFF;
      if (SEG_ACTIVE_LOW == 0) seg_next = ~seg_next;

      dp_on   = colon_on && (digit_idx == SLOT_MIN_L || digit_idx == SLOT_HRS_L);
      dp_next = (SEG_ACTIVE_LOW != 0) ? ~dp_on : dp_on;

      an_on   = (presc >= PRESC_BLANK) ? (6'b000001 << digit_idx) : '0;
      an_next = (AN_ACTIVE_LOW != 0) ? ~an_on : an_on;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         seg        <= SEG_IDLE;
         dp         <= DP_IDLE;
         an         <= AN_IDLE;
         digit_idx  <= SLOT_SEC_L;
         frame_done <= 1'b0;
         presc      <= '0;
         shadow     <= '0;
         colon_on   <= 1'b1;
         primed     <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         // The colon keeps time even while the display is dark.
         if (sec_tick) colon_on <= ~colon_on;

         if (en) begin
            seg <= seg_next;
            dp  <= dp_next;
            an  <= an_next;

            if (!primed) begin
               shadow     <= digits_in;
               frame_done <= 1'b1;
               primed     <= 1'b1;
            end

            if (presc == PRESC_LAST) begin
               presc <= '0;
               if (digit_idx == SLOT_HRS_M) begin
                  digit_idx  <= SLOT_SEC_L;
                  shadow     <= digits_in;
                  frame_done <= 1'b1;
               end else begin
                  digit_idx <= digit_idx + 3'd1;
               end
            end else begin
               presc <= presc + 1'b1;
            end
         end else begin
            seg <= SEG_IDLE;
            dp  <= DP_IDLE;
            an  <= AN_IDLE;
         end
      end
   end

endmodule
